// File: rtl/stream_pkg.sv
// Shared constants, types and helpers for the stream receive path.
package stream_pkg;

  localparam int DATA_WIDTH_DFLT = 8;

  typedef logic [DATA_WIDTH_DFLT-1:0] data_t;

  // Pointer width with one extra wrap bit to tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_rx_fifo_if.sv
// Upstream valid-only input plus downstream ready/valid handshake.
interface stream_rx_fifo_if
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT
) ();

  logic                  valid_bit_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (
    output valid_bit_in,
    output data_in,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  valid_bit_in,
    input  data_in,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/stream_rx_ram.sv
// FIFO storage: synchronous write, asynchronous read, contents never reset.
module stream_rx_ram
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/stream_rx_fifo.sv
// Absorbs a never-stalling valid-only stream into a FWFT FIFO, re-presents it
// on ready/valid, and records words lost to overflow.
module stream_rx_fifo
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int DEPTH      = 8,
  parameter int AF_MARGIN  = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stream_rx_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   drop_cnt,
  input  logic                   clear_ovf
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH - AF_MARGIN);

  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      count_r;
  logic                  overflow_r;
  logic [CNT_WIDTH-1:0]  drop_cnt_r;
  logic                  empty_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  // handshake qualifiers; a pop frees a slot for a same-cycle push when full
  always_comb begin
    empty_s = (rd_ptr_r == wr_ptr_r);
    full_s  = (rd_ptr_r[AW-1:0] == wr_ptr_r[AW-1:0]) && (rd_ptr_r[AW] != wr_ptr_r[AW]);
    pop_s   = !empty_s && bus.out_ready;
    push_s  = bus.valid_bit_in && (!full_s || pop_s);
    drop_s  = bus.valid_bit_in && full_s && !pop_s;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + PTR_W'(1);
        2'b01:   count_r <= count_r - PTR_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // loss tracking; a drop in the clearing cycle restarts the count at one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (clear_ovf) begin
        drop_cnt_r <= CNT_WIDTH'(1);
      end else if (drop_cnt_r != {CNT_WIDTH{1'b1}}) begin
        drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
      end
    end else if (clear_ovf) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_WIDTH{1'b0}};
    end
  end

  stream_rx_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (rdata_s)
  );

  // output decode; head word is masked to zero while empty
  always_comb begin
    bus.out_valid = !empty_s;
    if (empty_s) begin
      bus.out_data = {DATA_WIDTH{1'b0}};
    end else begin
      bus.out_data = rdata_s;
    end
    count       = count_r;
    almost_full = (count_r >= AF_LEVEL);
    overflow    = overflow_r;
    drop_cnt    = drop_cnt_r;
  end

endmodule

// File: tb/tb_stream_rx_fifo.sv
// Self-checking bench: table-driven fill/drain plus scoreboard-tracked sequences.
module tb_stream_rx_fifo;
  import stream_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst2_n;
  logic       clear_ovf, clear2;
  logic [3:0] count, count2;
  logic       almost_full, af2;
  logic       overflow, ovf2;
  logic [7:0] drop_cnt;
  logic [1:0] drop2;

  stream_rx_fifo_if #(.DATA_WIDTH(8)) bus  ();
  stream_rx_fifo_if #(.DATA_WIDTH(8)) bus2 ();

  stream_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_MARGIN(2), .CNT_WIDTH(8)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus), .count (count),
    .almost_full (almost_full), .overflow (overflow), .drop_cnt (drop_cnt),
    .clear_ovf (clear_ovf)
  );

  stream_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_MARGIN(2), .CNT_WIDTH(2)) dut2 (
    .clk (clk), .rst_n (rst2_n), .bus (bus2), .count (count2),
    .almost_full (af2), .overflow (ovf2), .drop_cnt (drop2),
    .clear_ovf (clear2)
  );

  int errors = 0;
  int checks = 0;

  // reference model for dut
  int    m_cnt  = 0;
  int    m_ovf  = 0;
  int    m_drop = 0;
  data_t exp_q[$];

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       clr;
    int         e_count;
    int         e_af;
    int         e_ovf;
    int         e_drop;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // one clock of dut with model update and post-edge comparison
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic c);
    bit pop, push, full, drop;
    data_t e;
    bus.valid_bit_in = v;
    bus.data_in      = d;
    bus.out_ready    = r;
    clear_ovf        = c;
    full = (m_cnt == 8);
    pop  = (m_cnt > 0) && r;
    push = v && (!full || pop);
    drop = v && full && !pop;
    if (pop) begin
      e = exp_q.pop_front();
      chk("pop_data", {24'd0, bus.out_data}, {24'd0, e});
    end
    if (push) exp_q.push_back(d);
    m_cnt = m_cnt + int'(push) - int'(pop);
    if (drop) begin
      m_ovf  = 1;
      m_drop = c ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    end else if (c) begin
      m_ovf  = 0;
      m_drop = 0;
    end
    @(posedge clk);
    #1;
    chk("count", {28'd0, count}, m_cnt);
    chk("out_valid", {31'd0, bus.out_valid}, (m_cnt > 0) ? 1 : 0);
    chk("almost_full", {31'd0, almost_full}, (m_cnt >= 6) ? 1 : 0);
    chk("overflow", {31'd0, overflow}, m_ovf);
    chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
    if (m_cnt == 0) chk("out_data_empty", {24'd0, bus.out_data}, 32'd0);
    else            chk("head", {24'd0, bus.out_data}, {24'd0, exp_q[0]});
  endtask

  task automatic cyc2(input logic v, input logic [7:0] d, input logic r);
    bus2.valid_bit_in = v;
    bus2.data_in      = d;
    bus2.out_ready    = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // fill 01..0A with no reader, then drain eight
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1, 0, 0, 0};
    tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 2, 0, 0, 0};
    tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 3, 0, 0, 0};
    tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 4, 0, 0, 0};
    tbl[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 5, 0, 0, 0};
    tbl[5]  = '{1'b1, 8'h06, 1'b0, 1'b0, 6, 1, 0, 0};
    tbl[6]  = '{1'b1, 8'h07, 1'b0, 1'b0, 7, 1, 0, 0};
    tbl[7]  = '{1'b1, 8'h08, 1'b0, 1'b0, 8, 1, 0, 0};
    tbl[8]  = '{1'b1, 8'h09, 1'b0, 1'b0, 8, 1, 1, 1};
    tbl[9]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 8, 1, 1, 2};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 7, 1, 1, 2};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 6, 1, 1, 2};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 5, 0, 1, 2};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 0, 1, 2};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 0, 1, 2};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 0, 1, 2};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 0, 1, 2};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 0, 1, 2};

    // reset with valid held high: nothing may be stored
    rst_n = 1'b0; rst2_n = 1'b0; clear_ovf = 1'b0; clear2 = 1'b0;
    bus.valid_bit_in = 1'b1; bus.data_in = 8'h77; bus.out_ready = 1'b0;
    bus2.valid_bit_in = 1'b0; bus2.data_in = 8'h00; bus2.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_af", {31'd0, almost_full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    rst_n = 1'b1; rst2_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // single word, first-word-fall-through
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("single_head", {24'd0, bus.out_data}, 32'h0000_00A5);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("single_empty", {31'd0, bus.out_valid}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].valid, tbl[i].data, tbl[i].ready, tbl[i].clr);
      chk($sformatf("tbl%0d_count", i), {28'd0, count}, tbl[i].e_count);
      chk($sformatf("tbl%0d_af", i), {31'd0, almost_full}, tbl[i].e_af);
      chk($sformatf("tbl%0d_ovf", i), {31'd0, overflow}, tbl[i].e_ovf);
      chk($sformatf("tbl%0d_drop", i), {24'd0, drop_cnt}, tbl[i].e_drop);
    end

    // full with simultaneous push and pop
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);
    chk("fullpp_count", {28'd0, count}, 32'd8);
    chk("fullpp_drop", {24'd0, drop_cnt}, 32'd0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullpp_last", {24'd0, bus.out_data}, 32'h0000_00FF);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // clear colliding with a drop, then a lone clear
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    chk("drop5", {24'd0, drop_cnt}, 32'd5);
    cyc(1'b1, 8'h3F, 1'b0, 1'b1);
    chk("collide_ovf", {31'd0, overflow}, 32'd1);
    chk("collide_drop", {24'd0, drop_cnt}, 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clear_ovf", {31'd0, overflow}, 32'd0);
    chk("clear_drop", {24'd0, drop_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // continuous streaming across pointer wrap
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
      chk("stream_cnt_le1", (count <= 4'd1) ? 32'd1 : 32'd0, 32'd1);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_drop", {24'd0, drop_cnt}, 32'd0);

    // narrow drop counter saturates
    for (int i = 0; i < 8; i++) cyc2(1'b1, 8'h50 + 8'(i), 1'b0);
    chk("sat_full", {28'd0, count2}, 32'd8);
    for (int i = 0; i < 5; i++) begin
      cyc2(1'b1, 8'h60, 1'b0);
      chk($sformatf("sat_drop%0d", i), {30'd0, drop2}, (i < 3) ? i + 1 : 3);
    end
    cyc2(1'b0, 8'h00, 1'b0);
    chk("sat_hold", {30'd0, drop2}, 32'd3);
    chk("sat_ovf", {31'd0, ovf2}, 32'd1);

    // reset mid-stream discards stored words
    rst2_n = 1'b0;
    cyc2(1'b0, 8'h00, 1'b0);
    rst2_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc2(1'b1, 8'hB1 + 8'(i), 1'b0);
    chk("mid_count4", {28'd0, count2}, 32'd4);
    rst2_n = 1'b0;
    cyc2(1'b0, 8'h00, 1'b0);
    chk("mid_rst_count", {28'd0, count2}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus2.out_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, bus2.out_data}, 32'd0);
    chk("mid_rst_drop", {30'd0, drop2}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf2}, 32'd0);
    rst2_n = 1'b1;
    cyc2(1'b1, 8'hC1, 1'b0);
    chk("post_rst_head", {24'd0, bus2.out_data}, 32'h0000_00C1);
    chk("post_rst_count", {28'd0, count2}, 32'd1);
    cyc2(1'b0, 8'h00, 1'b1);
    chk("post_rst_empty", {28'd0, count2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
